// File: rtl/ndro_readout_deser.sv
// NDRO readout deserializer: strobe + toggle -> bit, LSB-first word assembly, one-deep valid/ready buffer.
// Optional parity output enabled by defining NDRO_READOUT_DESER_PARITY_EN.
module ndro_readout_deser #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_strobe,
  input  logic             q_tgl,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_spurious,
  output logic             err_collide,
  output logic             err_overflow
`ifdef NDRO_READOUT_DESER_PARITY_EN
  , output logic           out_parity
`endif
);

  localparam int unsigned WIN_W = 4;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]       r_state,   w_state_nxt;
  logic [WIN_W-1:0] r_win_cnt, w_win_cnt_nxt;
  logic             r_hit,     w_hit_nxt;
  logic [WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic             r_q_prev;
  logic             w_tog;
  logic             w_bit;
  logic [WIDTH-1:0] w_word;
  logic             w_set_spur;
  logic             w_set_coll;
  logic             w_set_ovf;
  logic             w_load;

  assign w_tog  = (q_tgl != r_q_prev);
  assign w_bit  = r_hit | w_tog;
  assign w_word = {w_bit, r_shift[WIDTH-1:1]};

  // Next-state, window/bit bookkeeping and error/load strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_win_cnt_nxt = r_win_cnt;
    w_hit_nxt     = r_hit;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_set_spur    = 1'b0;
    w_set_coll    = 1'b0;
    w_set_ovf     = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rd_strobe) begin
          w_state_nxt   = ST_WAIT;
          w_win_cnt_nxt = WIN_W'(WINDOW - 1);
          w_hit_nxt     = w_tog;
        end else if (w_tog) begin
          w_set_spur = 1'b1;
        end
      end
      ST_WAIT: begin
        if (rd_strobe) w_set_coll = 1'b1;
        if (w_tog) begin
          if (r_hit) w_set_spur = 1'b1;
          w_hit_nxt = 1'b1;
        end
        if (r_win_cnt == '0) begin
          w_shift_nxt = w_word;
          w_state_nxt = ST_IDLE;
          if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
            w_bit_cnt_nxt = '0;
            // Buffer is free if empty or being drained this very cycle
            if (!out_valid || out_ready) w_load = 1'b1;
            else                         w_set_ovf = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end else begin
          w_win_cnt_nxt = r_win_cnt - WIN_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers; q_prev tracks the line even in reset
  always_ff @(posedge clk) begin
    r_q_prev <= q_tgl;
    if (rst) begin
      r_state   <= ST_IDLE;
      r_win_cnt <= '0;
      r_hit     <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_win_cnt <= w_win_cnt_nxt;
      r_hit     <= w_hit_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Output buffer and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      err_spurious <= 1'b0;
      err_collide  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        out_data  <= w_word;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_set_spur) err_spurious <= 1'b1;
      if (w_set_coll) err_collide  <= 1'b1;
      if (w_set_ovf)  err_overflow <= 1'b1;
    end
  end

`ifdef NDRO_READOUT_DESER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)         out_parity <= 1'b0;
    else if (w_load) out_parity <= ^w_word;
  end
`endif

endmodule

// File: tb/tb_ndro_readout_deser.sv
// Directed bench for ndro_readout_deser (WIDTH=8, WINDOW=4) with immediate-assertion checks.
// Parity checks are active when NDRO_READOUT_DESER_PARITY_EN is defined.
module tb_ndro_readout_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_strobe;
  logic       q_tgl;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err_spurious;
  logic       err_collide;
  logic       err_overflow;
`ifdef NDRO_READOUT_DESER_PARITY_EN
  logic       out_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_accept = 0;
  logic [7:0] acc_data = '0;
  logic       acc_par  = 1'b0;
  int base_acc;

  ndro_readout_deser #(.WIDTH(8), .WINDOW(4), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_strobe    (rd_strobe),
    .q_tgl        (q_tgl),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_spurious (err_spurious),
    .err_collide  (err_collide),
    .err_overflow (err_overflow)
`ifdef NDRO_READOUT_DESER_PARITY_EN
    , .out_parity (out_parity)
`endif
  );

  always #5 clk = ~clk;

  // Record every accepted word
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_accept <= n_accept + 1;
      acc_data <= out_data;
`ifdef NDRO_READOUT_DESER_PARITY_EN
      acc_par  <= out_parity;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One read slot of 6 cycles; toggle (if b) sampled dly edges after the strobe edge
  task automatic send_bit(input logic b, input int dly);
    rd_strobe = 1'b1;
    if (b && dly == 0) q_tgl = ~q_tgl;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) rd_strobe = 1'b0;
      if (b && (i + 1 == dly)) q_tgl = ~q_tgl;
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], 2);
  endtask

  initial begin
    rst = 1'b1; rd_strobe = 1'b0; q_tgl = 1'b0; out_ready = 1'b1;
    tick();
    do_reset();

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_spur", 32'(err_spurious), 32'd0);
    check("rst_coll", 32'(err_collide), 32'd0);
    check("rst_ovf", 32'(err_overflow), 32'd0);
`ifdef NDRO_READOUT_DESER_PARITY_EN
    check("rst_par", 32'(out_parity), 32'd0);
`endif

    // Basic word: ones at bits 0,2,3,7 -> 8'h8D, valid 5 cycles after last strobe
    for (int i = 0; i < 7; i++) send_bit((i == 0) || (i == 2) || (i == 3), 2);
    check("basic_novalid_early", 32'(out_valid), 32'd0);
    rd_strobe = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) rd_strobe = 1'b0;
      if (i == 2) q_tgl = ~q_tgl;
      if (i == 4) check("basic_valid_t4", 32'(out_valid), 32'd0);
      if (i == 5) begin
        check("basic_valid_t5", 32'(out_valid), 32'd1);
        check("basic_data", 32'(out_data), 32'h8D);
`ifdef NDRO_READOUT_DESER_PARITY_EN
        check("basic_parity", 32'(out_parity), 32'd0);
`endif
      end
      if (i == 6) check("basic_valid_t6", 32'(out_valid), 32'd0);
    end
    check("basic_accepts", 32'(n_accept), 32'd1);
    check("basic_spur", 32'(err_spurious), 32'd0);
    check("basic_coll", 32'(err_collide), 32'd0);
    check("basic_ovf", 32'(err_overflow), 32'd0);

    // Window edge: toggle at 4 cycles is a hit, at 5 cycles is spurious and a zero
    send_bit(1'b1, 4);
    check("win4_nospur", 32'(err_spurious), 32'd0);
    send_bit(1'b1, 5);
    check("win5_spur", 32'(err_spurious), 32'd1);
    for (int i = 2; i < 8; i++) send_bit(1'b0, 2);
    check("win_accepts", 32'(n_accept), 32'd2);
    check("win_word", 32'(acc_data), 32'h01);
`ifdef NDRO_READOUT_DESER_PARITY_EN
    check("win_parity", 32'(acc_par), 32'd1);
`endif

    // Collision: second strobe 2 cycles into the window; only one bit advances
    do_reset();
    base_acc = n_accept;
    rd_strobe = 1'b1;
    tick(); rd_strobe = 1'b0;
    tick(); q_tgl = ~q_tgl; rd_strobe = 1'b1;
    tick(); rd_strobe = 1'b0;
    tick(); tick(); tick();
    check("coll_flag", 32'(err_collide), 32'd1);
    check("coll_nospur", 32'(err_spurious), 32'd0);
    send_bit(1'b1, 2); send_bit(1'b0, 2); send_bit(1'b1, 2);
    send_bit(1'b0, 2); send_bit(1'b0, 2); send_bit(1'b1, 2);
    check("coll_noword_7bits", 32'(n_accept - base_acc), 32'd0);
    send_bit(1'b0, 2);
    check("coll_word_8bits", 32'(n_accept - base_acc), 32'd1);
    check("coll_word", 32'(acc_data), 32'h4B);

    // Backpressure: second word overflows and is dropped
    do_reset();
    out_ready = 1'b0;
    send_word(8'hFF);
    check("bp_valid1", 32'(out_valid), 32'd1);
    check("bp_data1", 32'(out_data), 32'hFF);
    check("bp_noovf", 32'(err_overflow), 32'd0);
    send_word(8'h00);
    check("bp_valid2", 32'(out_valid), 32'd1);
    check("bp_data2", 32'(out_data), 32'hFF);
    check("bp_ovf", 32'(err_overflow), 32'd1);
    base_acc = n_accept;
    out_ready = 1'b1;
    tick();
    check("bp_drop_valid", 32'(out_valid), 32'd0);
    check("bp_acc_count", 32'(n_accept - base_acc), 32'd1);
    check("bp_acc_data", 32'(acc_data), 32'hFF);

    // Reset mid-word and mid-window with q_tgl raised during reset
    do_reset();
    base_acc = n_accept;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 2);
    rd_strobe = 1'b1;
    tick(); rd_strobe = 1'b0;
    tick();
    rst = 1'b1; q_tgl = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("mid_nospur", 32'(err_spurious), 32'd0);
    check("mid_novalid", 32'(out_valid), 32'd0);
    check("mid_noacc", 32'(n_accept - base_acc), 32'd0);
    send_word(8'h5A);
    check("mid_fresh_count", 32'(n_accept - base_acc), 32'd1);
    check("mid_fresh_word", 32'(acc_data), 32'h5A);
    check("mid_fresh_nospur", 32'(err_spurious), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
